// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline sequencing controller for the five-stage RISC-V core.
//
// It looks at the ID, EX and MEM stages and drives the stall, bubble and
// flush controls. It also runs a handshake FSM that freezes the whole pipeline
// while a variable-latency data-memory access is outstanding, and it keeps two
// saturating performance counters.
//
// Parameters
//   MAX_WAIT : number of MEM_WAIT cycles allowed without an ack before the
//              controller gives up and enters ERROR.
//   CNT_W    : width of the performance counters.
//
// Ports
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   IF_ID_Rs1_i/Rs2_i   source registers of the instruction in ID
//   ID_Branch_i         instruction in ID is a branch
//   ID_BranchTaken_i    ID comparator resolves the branch as taken
//   ID_EX_Rd_i          destination register of the instruction in EX
//   ID_EX_MemRead_i     instruction in EX is a load
//   ID_EX_RegWrite_i    instruction in EX writes a register
//   EX_MEM_MemAccess_i  instruction in MEM is a load or a store
//   DMem_Ack_i          one-cycle pulse: data memory access complete
//   PCWrite_o           PC update enable
//   IF_ID_Write_o       IF/ID register enable
//   IF_ID_Flush_o       zeroes IF/ID on the next edge
//   NoOp_o              insert a bubble into ID/EX (feeds decoder NoOp_i)
//   Pipe_Stall_o        freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB
//   DMem_Start_o        one-cycle pulse: launch the data memory access
//   Err_Timeout_o       sticky memory-timeout flag
//   Stall_Cnt_o         cycles with PCWrite_o=0, saturating
//   Flush_Cnt_o         cycles with IF_ID_Flush_o=1, saturating
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int MAX_WAIT = 64,
   parameter int CNT_W    = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       IF_ID_Rs1_i,
   input  logic [4:0]       IF_ID_Rs2_i,
   input  logic             ID_Branch_i,
   input  logic             ID_BranchTaken_i,
   input  logic [4:0]       ID_EX_Rd_i,
   input  logic             ID_EX_MemRead_i,
   input  logic             ID_EX_RegWrite_i,
   input  logic             EX_MEM_MemAccess_i,
   input  logic             DMem_Ack_i,
   output logic             PCWrite_o,
   output logic             IF_ID_Write_o,
   output logic             IF_ID_Flush_o,
   output logic             NoOp_o,
   output logic             Pipe_Stall_o,
   output logic             DMem_Start_o,
   output logic             Err_Timeout_o,
   output logic [CNT_W-1:0] Stall_Cnt_o,
   output logic [CNT_W-1:0] Flush_Cnt_o
);

   // The wait counter holds the number of MEM_WAIT cycles already spent,
   // so it only ever needs to reach MAX_WAIT-1.
   localparam int                WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   // Hazard detection terms
   logic rd_nonzero;
   logic rd_match;
   logic load_use;
   logic branch_dep;
   logic hazard_stall;
   logic branch_taken;

   // Combinational control outputs before being driven out
   logic pipe_stall;
   logic dmem_start;
   logic pc_write;
   logic if_id_write;
   logic if_id_flush;
   logic no_op;

   // --------------------------------------------------------------------------
   // Hazard terms
   // --------------------------------------------------------------------------
   always_comb begin
      rd_nonzero   = |ID_EX_Rd_i;
      rd_match     = (ID_EX_Rd_i == IF_ID_Rs1_i) | (ID_EX_Rd_i == IF_ID_Rs2_i);
      load_use     = ID_EX_MemRead_i & rd_nonzero & rd_match;
      // The ID comparator cannot see the EX result, so a branch that depends
      // on a register being written in EX has to wait one cycle.
      branch_dep   = ID_Branch_i & ID_EX_RegWrite_i & rd_nonzero & rd_match;
      hazard_stall = load_use | branch_dep;
      branch_taken = ID_Branch_i & ID_BranchTaken_i;
   end

   // --------------------------------------------------------------------------
   // Pipeline controls: combinational from current state and inputs.
   // --------------------------------------------------------------------------
   always_comb begin
      pipe_stall = 1'b0;
      dmem_start = 1'b0;

      case (state_q)
         ST_RUN: begin
            // A new access in MEM is launched here. A same-cycle ack is a
            // zero-wait access and the pipeline keeps moving.
            dmem_start = EX_MEM_MemAccess_i;
            pipe_stall = EX_MEM_MemAccess_i & ~DMem_Ack_i;
         end
         ST_MEM_WAIT: begin
            // The ack cycle releases the pipeline immediately.
            pipe_stall = ~DMem_Ack_i;
         end
         ST_ERROR: begin
            pipe_stall = 1'b1;
         end
         default: begin
            pipe_stall = 1'b1;
         end
      endcase

      // Priority: memory stall, then hazard bubble, then taken-branch flush.
      // During a memory stall the branch stays in ID, so its flush is simply
      // deferred until the pipeline moves again.
      if (pipe_stall) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         no_op       = 1'b0;
         if_id_flush = 1'b0;
      end else if (hazard_stall) begin
         // A branch outcome is not trusted while its operand is still in EX.
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         no_op       = 1'b1;
         if_id_flush = 1'b0;
      end else if (branch_taken) begin
         pc_write    = 1'b1;
         if_id_write = 1'b1;
         no_op       = 1'b0;
         if_id_flush = 1'b1;
      end else begin
         pc_write    = 1'b1;
         if_id_write = 1'b1;
         no_op       = 1'b0;
         if_id_flush = 1'b0;
      end

      // Outputs are held at their safe values for as long as reset is high.
      if (rst_i) begin
         pipe_stall  = 1'b0;
         dmem_start  = 1'b0;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         no_op       = 1'b1;
         if_id_flush = 1'b0;
      end
   end

   // --------------------------------------------------------------------------
   // Memory handshake FSM next state
   // --------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;

      case (state_q)
         ST_RUN: begin
            if (EX_MEM_MemAccess_i && !DMem_Ack_i) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = '0;
            end
         end
         ST_MEM_WAIT: begin
            // An ack on the last permitted cycle still wins over the timeout.
            if (DMem_Ack_i) begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = ST_ERROR;
               err_d   = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         ST_ERROR: begin
            // Only reset leaves ERROR; acks are ignored.
            state_d = ST_ERROR;
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Saturating performance counters
   // --------------------------------------------------------------------------
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (if_id_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // --------------------------------------------------------------------------
   // Output drive
   // --------------------------------------------------------------------------
   assign PCWrite_o     = pc_write;
   assign IF_ID_Write_o = if_id_write;
   assign IF_ID_Flush_o = if_id_flush;
   assign NoOp_o        = no_op;
   assign Pipe_Stall_o  = pipe_stall;
   assign DMem_Start_o  = dmem_start;
   assign Err_Timeout_o = err_q;
   assign Stall_Cnt_o   = stall_cnt_q;
   assign Flush_Cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Scoreboard bench for hazard_ctrl. The stimulus process drives one cycle at a
// time, asks a behavioural model what the controller must show in that cycle
// and queues the answer; a separate monitor pops and compares at the falling
// edge. A small counter width is used so counter saturation is reachable.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int  MAX_WAIT = 64;
   localparam int  CNT_W    = 8;
   localparam longint CMAX  = (longint'(1) << CNT_W) - 1;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [4:0]       IF_ID_Rs1_i, IF_ID_Rs2_i, ID_EX_Rd_i;
   logic             ID_Branch_i, ID_BranchTaken_i;
   logic             ID_EX_MemRead_i, ID_EX_RegWrite_i;
   logic             EX_MEM_MemAccess_i, DMem_Ack_i;
   logic             PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, NoOp_o;
   logic             Pipe_Stall_o, DMem_Start_o, Err_Timeout_o;
   logic [CNT_W-1:0] Stall_Cnt_o, Flush_Cnt_o;

   hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .IF_ID_Rs1_i        (IF_ID_Rs1_i),
      .IF_ID_Rs2_i        (IF_ID_Rs2_i),
      .ID_Branch_i        (ID_Branch_i),
      .ID_BranchTaken_i   (ID_BranchTaken_i),
      .ID_EX_Rd_i         (ID_EX_Rd_i),
      .ID_EX_MemRead_i    (ID_EX_MemRead_i),
      .ID_EX_RegWrite_i   (ID_EX_RegWrite_i),
      .EX_MEM_MemAccess_i (EX_MEM_MemAccess_i),
      .DMem_Ack_i         (DMem_Ack_i),
      .PCWrite_o          (PCWrite_o),
      .IF_ID_Write_o      (IF_ID_Write_o),
      .IF_ID_Flush_o      (IF_ID_Flush_o),
      .NoOp_o             (NoOp_o),
      .Pipe_Stall_o       (Pipe_Stall_o),
      .DMem_Start_o       (DMem_Start_o),
      .Err_Timeout_o      (Err_Timeout_o),
      .Stall_Cnt_o        (Stall_Cnt_o),
      .Flush_Cnt_o        (Flush_Cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       mem_read;
      logic       reg_write;
      logic       branch;
      logic       taken;
      logic       mem_access;
      logic       ack;
   } stim_t;

   typedef struct packed {
      logic             pcw;
      logic             ifw;
      logic             flush;
      logic             noop;
      logic             stall;
      logic             start;
      logic             err;
      logic [CNT_W-1:0] scnt;
      logic [CNT_W-1:0] fcnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   // ---------------------------------------------------------------------------
   // Behavioural model: the controller is either idle, waiting on memory (with
   // a count of cycles already waited) or dead after a timeout.
   // ---------------------------------------------------------------------------
   bit     m_waiting = 0;
   bit     m_dead    = 0;
   int     m_waited  = 0;
   bit     m_err     = 0;
   longint m_scnt    = 0;
   longint m_fcnt    = 0;

   function automatic exp_t predict(stim_t s);
      exp_t e;
      bit   hazard, mem_frozen;
      e.err  = m_err;
      e.scnt = CNT_W'(m_scnt);
      e.fcnt = CNT_W'(m_fcnt);
      if (s.rst) begin
         e.pcw = 0; e.ifw = 0; e.flush = 0; e.noop = 1; e.stall = 0; e.start = 0;
         return e;
      end
      hazard = (s.rd != 0) && (s.rd == s.rs1 || s.rd == s.rs2) &&
               (s.mem_read || (s.branch && s.reg_write));
      if (m_dead)         begin mem_frozen = 1;        e.start = 0; end
      else if (m_waiting) begin mem_frozen = !s.ack;   e.start = 0; end
      else begin
         mem_frozen = s.mem_access && !s.ack;
         e.start    = s.mem_access;
      end
      e.stall = mem_frozen;
      e.noop  = !mem_frozen && hazard;
      e.pcw   = !mem_frozen && !hazard;
      e.ifw   = e.pcw;
      e.flush = !mem_frozen && !hazard && s.branch && s.taken;
      return e;
   endfunction

   task automatic model_step(stim_t s, exp_t e);
      if (s.rst) begin
         m_waiting = 0; m_dead = 0; m_waited = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
         return;
      end
      if (m_waiting) begin
         if (s.ack) m_waiting = 0;
         else if (m_waited + 1 == MAX_WAIT) begin
            m_waiting = 0; m_dead = 1; m_err = 1;
         end else m_waited++;
      end else if (!m_dead && s.mem_access && !s.ack) begin
         m_waiting = 1; m_waited = 0;
      end
      if (!e.pcw && m_scnt < CMAX) m_scnt++;
      if (e.flush && m_fcnt < CMAX) m_fcnt++;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.rs1 = 5'd1; s.rs2 = 5'd2; s.rd = 5'd3;
      return s;
   endfunction

   function automatic stim_t rand_stim(bit no_ack);
      stim_t s;
      s            = '0;
      s.rs1        = 5'($urandom_range(0, 3));
      s.rs2        = 5'($urandom_range(0, 3));
      s.rd         = 5'($urandom_range(0, 3));
      s.mem_read   = 1'($urandom_range(0, 2) == 0);
      s.reg_write  = 1'($urandom_range(0, 1));
      s.branch     = 1'($urandom_range(0, 2) == 0);
      s.taken      = 1'($urandom_range(0, 1));
      s.mem_access = 1'($urandom_range(0, 4) == 0);
      s.ack        = no_ack ? 1'b0 : 1'($urandom_range(0, 2) == 0);
      return s;
   endfunction

   task automatic cycle(stim_t s);
      exp_t e;
      @(posedge clk_i);
      #1;
      rst_i              = s.rst;
      IF_ID_Rs1_i        = s.rs1;
      IF_ID_Rs2_i        = s.rs2;
      ID_EX_Rd_i         = s.rd;
      ID_EX_MemRead_i    = s.mem_read;
      ID_EX_RegWrite_i   = s.reg_write;
      ID_Branch_i        = s.branch;
      ID_BranchTaken_i   = s.taken;
      EX_MEM_MemAccess_i = s.mem_access;
      DMem_Ack_i         = s.ack;
      if (s.rst) model_step(s, '0);
      e = predict(s);
      exp_q.push_back(e);
      if (!s.rst) model_step(s, e);
   endtask

   // ---------------------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------------------
   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL cyc=%0d %s: got %0d, expected %0d", cyc, name, act, req);
      end
   endfunction

   initial begin
      forever begin
         @(negedge clk_i);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cyc++;
            $display("cyc %0d rst=%b stall=%b noop=%b pcw=%b ifw=%b flush=%b start=%b err=%b scnt=%0d fcnt=%0d",
                     cyc, rst_i, Pipe_Stall_o, NoOp_o, PCWrite_o, IF_ID_Write_o,
                     IF_ID_Flush_o, DMem_Start_o, Err_Timeout_o, Stall_Cnt_o, Flush_Cnt_o);
            check("PCWrite_o",     32'(PCWrite_o),     32'(e.pcw));
            check("IF_ID_Write_o", 32'(IF_ID_Write_o), 32'(e.ifw));
            check("IF_ID_Flush_o", 32'(IF_ID_Flush_o), 32'(e.flush));
            check("NoOp_o",        32'(NoOp_o),        32'(e.noop));
            check("Pipe_Stall_o",  32'(Pipe_Stall_o),  32'(e.stall));
            check("DMem_Start_o",  32'(DMem_Start_o),  32'(e.start));
            check("Err_Timeout_o", 32'(Err_Timeout_o), 32'(e.err));
            check("Stall_Cnt_o",   32'(Stall_Cnt_o),   32'(e.scnt));
            check("Flush_Cnt_o",   32'(Flush_Cnt_o),   32'(e.fcnt));
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      stim_t s;
      s = idle();
      s.rst = 1;
      rst_i = 1;
      IF_ID_Rs1_i = '0; IF_ID_Rs2_i = '0; ID_EX_Rd_i = '0;
      ID_Branch_i = 0; ID_BranchTaken_i = 0; ID_EX_MemRead_i = 0;
      ID_EX_RegWrite_i = 0; EX_MEM_MemAccess_i = 0; DMem_Ack_i = 0;
      repeat (2) cycle(s);

      // Load-use on rs2, then the same pattern with rd = x0
      s = idle(); s.mem_read = 1; s.rd = 5'd5; s.rs2 = 5'd5; cycle(s);
      s = idle(); cycle(s);
      s = idle(); s.mem_read = 1; s.rd = 5'd0; s.rs1 = 5'd0; s.rs2 = 5'd0; cycle(s);

      // Taken branch without hazard, then not taken
      s = idle(); s.branch = 1; s.taken = 1; cycle(s);
      s = idle(); s.branch = 1; s.taken = 0; cycle(s);

      // Branch on x7 while an ALU op writing x7 is in EX, taken
      s = idle(); s.branch = 1; s.taken = 1; s.rs1 = 5'd7; s.rd = 5'd7; s.reg_write = 1; cycle(s);
      s = idle(); s.branch = 1; s.taken = 1; s.rs1 = 5'd7; s.rd = 5'd7; cycle(s);
      s = idle(); cycle(s);

      // Store in MEM acked three cycles after the start pulse, then zero-wait
      for (int i = 0; i < 4; i++) begin
         s = idle(); s.mem_access = 1; s.ack = (i == 3); cycle(s);
      end
      s = idle(); cycle(s);
      s = idle(); s.mem_access = 1; s.ack = 1; cycle(s);
      s = idle(); cycle(s);

      // Memory stall coinciding with a taken branch in ID
      for (int i = 0; i < 3; i++) begin
         s = idle(); s.mem_access = 1; s.ack = (i == 2); s.branch = 1; s.taken = 1; cycle(s);
      end
      s = idle(); cycle(s);

      // Randomized traffic
      for (int i = 0; i < 700; i++) cycle(rand_stim(0));

      // Timeout: access with no ack, acks ignored once dead
      s = idle(); s.rst = 1; cycle(s);
      s = idle(); cycle(s);
      for (int i = 0; i < MAX_WAIT + 6; i++) begin
         s = rand_stim(1); s.mem_access = 1; cycle(s);
      end
      for (int i = 0; i < 5; i++) begin
         s = rand_stim(0); s.ack = 1; cycle(s);
      end

      // Reset from ERROR, then a little more random traffic
      s = rand_stim(0); s.rst = 1; cycle(s);
      s = rand_stim(0); s.rst = 1; cycle(s);
      for (int i = 0; i < 150; i++) cycle(rand_stim(0));

      repeat (3) @(negedge clk_i);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage RISC-V core. It watches the ID, EX and MEM stages and drives the stall, bubble and flush controls. NoOp_o feeds the main decoder's NoOp_i. It also runs a handshake FSM that freezes the whole pipeline while a variable-latency data-memory access is outstanding, and it keeps saturating performance counters.

## Interface
- MAX_WAIT, 64: maximum cycles spent in MEM_WAIT before a timeout error.
- CNT_W, 32: width of the performance counters.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- IF_ID_Rs1_i, IF_ID_Rs2_i  in  5 each  source registers of the instruction in ID.
- ID_Branch_i  in  1  instruction in ID is a branch (decoder Branch_o).
- ID_BranchTaken_i  in  1  ID comparator resolves the branch as taken.
- ID_EX_Rd_i  in  5  destination register of the instruction in EX.
- ID_EX_MemRead_i  in  1  instruction in EX is a load.
- ID_EX_RegWrite_i  in  1  instruction in EX writes a register.
- EX_MEM_MemAccess_i  in  1  instruction in MEM is a load or a store.
- DMem_Ack_i  in  1  one-cycle pulse: data memory access complete.
- PCWrite_o  out  1  PC update enable.
- IF_ID_Write_o  out  1  IF/ID register enable.
- IF_ID_Flush_o  out  1  zeroes IF/ID on the next edge.
- NoOp_o  out  1  insert a bubble into ID/EX.
- Pipe_Stall_o  out  1  freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- DMem_Start_o  out  1  one-cycle pulse: launch the data memory access.
- Err_Timeout_o  out  1  sticky timeout flag.
- Stall_Cnt_o  out  CNT_W  cycles with PCWrite_o=0, saturating.
- Flush_Cnt_o  out  CNT_W  asserted IF_ID_Flush_o cycles, saturating.

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- **RUN**
  - When EX_MEM_MemAccess_i=1, assert DMem_Start_o.
  - If DMem_Ack_i=1 in the same cycle (zero-wait access), stay in RUN with no stall.
  - Otherwise assert Pipe_Stall_o and move to MEM_WAIT.
- **MEM_WAIT**
  - Pipe_Stall_o=1 and DMem_Start_o=0.
  - A wait counter increments each cycle.
  - On DMem_Ack_i, Pipe_Stall_o=0 that cycle (the pipeline advances) and the FSM returns to RUN.
  - If the counter reaches MAX_WAIT without an ack, the FSM moves to ERROR and Err_Timeout_o is set.
  - The wait counter clears on entry to MEM_WAIT.
- **ERROR**
  - Pipe_Stall_o=1 permanently and the FSM ignores DMem_Ack_i.
  - Exit is by reset only.
- **Hazard terms** (combinational)
  - LU (load-use) = ID_EX_MemRead_i & (ID_EX_Rd_i≠0) & (ID_EX_Rd_i==IF_ID_Rs1_i | ID_EX_Rd_i==IF_ID_Rs2_i).
  - BR = ID_Branch_i & ID_EX_RegWrite_i & (ID_EX_Rd_i≠0) & (ID_EX_Rd_i matches Rs1 or Rs2). The ID comparator cannot see the EX result, so a branch that depends on it must wait one cycle.
  - HS (hazard stall) = LU | BR.
- **Priority**
  - If Pipe_Stall_o=1: PCWrite_o=0, IF_ID_Write_o=0, NoOp_o=0, IF_ID_Flush_o=0. The flush is deferred because the branch stays in ID.
  - Else if HS: PCWrite_o=0, IF_ID_Write_o=0, NoOp_o=1, IF_ID_Flush_o=0. The branch outcome is not trusted while HS is active.
  - Else if ID_Branch_i & ID_BranchTaken_i: PCWrite_o=1, IF_ID_Write_o=1, IF_ID_Flush_o=1, NoOp_o=0.
  - Else: PCWrite_o=1, IF_ID_Write_o=1, NoOp_o=0, IF_ID_Flush_o=0.
- **Counters**
  - Stall_Cnt_o increments on every non-reset cycle with PCWrite_o=0.
  - Flush_Cnt_o increments on every cycle with IF_ID_Flush_o=1.
  - Both saturate at 2^CNT_W−1.

## Timing
- **While rst_i=1** (asynchronous)
  - State is RUN; the wait counter, both performance counters and Err_Timeout_o are 0.
  - Outputs are forced: PCWrite_o=0, IF_ID_Write_o=0, NoOp_o=1, IF_ID_Flush_o=0, Pipe_Stall_o=0, DMem_Start_o=0.
- Reset asserted in MEM_WAIT or ERROR returns the FSM to RUN immediately. There is no pending ack bookkeeping.
- Pipe_Stall_o, NoOp_o, PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o and DMem_Start_o are combinational from the current state and inputs, with zero latency. The path DMem_Ack_i → Pipe_Stall_o is combinational.
- DMem_Start_o is high for exactly one cycle per access: the RUN cycle in which the access is first seen. It is never high in MEM_WAIT.
- A load-use hazard costs exactly 1 stall cycle. A branch waiting on an EX result costs 1 stall cycle, plus 1 flush cycle if taken.
- A memory access acked k cycles after DMem_Start_o (k≥1) holds Pipe_Stall_o for k cycles.
- Timeout: ERROR is entered on the edge after the MAX_WAIT-th MEM_WAIT cycle without an ack.

## Test plan
- Load x5 in EX, ID reads x5 as rs2 → NoOp_o=1, PCWrite_o=0 for 1 cycle; Stall_Cnt_o=1. Repeat with rd=x0 → no stall.
- Taken branch in ID with no hazards → IF_ID_Flush_o=1 for 1 cycle; Flush_Cnt_o=1. Not taken → no flush.
- Branch in ID reading x7 while an ADD writing x7 is in EX, taken → 1 stall cycle with NoOp_o=1, then a flush cycle; Stall_Cnt_o=1, Flush_Cnt_o=1.
- Store in MEM, ack 3 cycles after the start pulse → DMem_Start_o pulses once, Pipe_Stall_o=1 for 3 cycles, return to RUN. A zero-wait ack → no stall.
- Memory stall coinciding with a taken branch in ID → flush suppressed during the stall and asserted on the ack cycle.
- No ack for MAX_WAIT=64 cycles → Err_Timeout_o=1 and Pipe_Stall_o stuck at 1. Reset mid-ERROR → all outputs at reset values, FSM in RUN.
